// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//   Multi-channel LED driver for the car body lights. A single clock domain
//   drives the blink divider, the PWM dimmer, the per-channel manual/automatic
//   request logic and a beat-driven ping-pong chase ("dance" mode).
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   master_toggle 1-clk pulse, toggles the master enable
//   ch_toggle     1-clk pulses, toggle the per-channel manual enables
//   auto_req      level, automatic request per channel (stop/back/turn decode)
//   blink_mask    level, 1 = channel blinks, 0 = channel steady
//   duty          global brightness, 0 = off, all-ones = fully on
//   dance_en      level, dance mode request
//   beat          1-clk pulse per music beat, advances the chase
//   led           registered LED drive
//   dance_pos     current chase position
// -----------------------------------------------------------------------------
module led_sequencer #(
  parameter  int NUM_CH    = 5,
  parameter  int BLINK_DIV = 25_000_000,
  parameter  int PWM_W     = 8,
  localparam int POS_W     = $clog2(NUM_CH) | 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              master_toggle,
  input  logic [NUM_CH-1:0] ch_toggle,
  input  logic [NUM_CH-1:0] auto_req,
  input  logic [NUM_CH-1:0] blink_mask,
  input  logic [PWM_W-1:0]  duty,
  input  logic              dance_en,
  input  logic              beat,
  output logic [NUM_CH-1:0] led,
  output logic [POS_W-1:0]  dance_pos
);

  localparam int              CNT_W    = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST   = POS_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_FWD    = 2'd1,
    ST_REV    = 2'd2
  } state_t;

  // Registered state
  logic              master_on_q, master_on_d;
  logic [NUM_CH-1:0] man_on_q,    man_on_d;
  logic [CNT_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic              blink_ph_q,  blink_ph_d;
  logic [PWM_W-1:0]  pwm_cnt_q,   pwm_cnt_d;
  logic [NUM_CH-1:0] led_q,       led_d;
  logic              dance_en_q;
  state_t            state_q;
  logic [POS_W-1:0]  dance_pos_q;

  // Combinational helpers
  logic              blink_wrap;
  logic              pwm_on;
  logic              dance_rise;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] blink_gate;
  logic [NUM_CH-1:0] normal_nxt;
  logic [NUM_CH-1:0] dance_nxt;

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a value on every path first, so no
    // latch can be inferred even if a later branch is edited carelessly.
    master_on_d = master_on_q ^ master_toggle;
    man_on_d    = man_on_q ^ ch_toggle;   // toggles even while master is off

    blink_wrap  = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_ph_d  = blink_ph_q ^ blink_wrap;

    pwm_cnt_d   = pwm_cnt_q + 1'b1;
    // All-ones duty is forced fully on; otherwise the counter compare would
    // leave one dark slot per PWM period.
    pwm_on      = (&duty) | (pwm_cnt_q < duty);

    dance_rise  = dance_en & ~dance_en_q;

    req         = man_on_q | auto_req;
    // Steady channels pass; blinking channels follow the blink phase.
    blink_gate  = ~blink_mask | {NUM_CH{blink_ph_q}};
    normal_nxt  = req & blink_gate & {NUM_CH{master_on_q & pwm_on}};

    dance_nxt   = (NUM_CH'(1) << dance_pos_q) & {NUM_CH{pwm_on}};

    led_d       = (state_q == ST_NORMAL) ? normal_nxt : dance_nxt;
  end

  // ---------------------------------------------------------------------------
  // Enables, divider, PWM counter and LED output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      master_on_q <= 1'b0;
      man_on_q    <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      pwm_cnt_q   <= '0;
      led_q       <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so all
      // registers sample the pre-edge values regardless of statement order.
      master_on_q <= master_on_d;
      man_on_q    <= man_on_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      pwm_cnt_q   <= pwm_cnt_d;
      led_q       <= led_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Dance FSM: ping-pong chase advanced by beat pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_NORMAL;
      dance_pos_q <= '0;
      dance_en_q  <= 1'b0;
    end else begin
      dance_en_q <= dance_en;
      if (!dance_en) begin
        // Leaving dance mode from any state; manual/master state is untouched.
        state_q     <= ST_NORMAL;
        dance_pos_q <= '0;
      end else begin
        unique case (state_q)
          ST_NORMAL: begin
            // A beat in the entry cycle is ignored: the chase starts at 0.
            if (dance_rise) begin
              state_q     <= ST_FWD;
              dance_pos_q <= '0;
            end
          end
          ST_FWD: begin
            // A single channel has nowhere to move; stay at 0 in FWD.
            if (beat && NUM_CH > 1) begin
              if (dance_pos_q == POS_LAST) begin
                state_q     <= ST_REV;
                dance_pos_q <= dance_pos_q - 1'b1;
              end else begin
                dance_pos_q <= dance_pos_q + 1'b1;
              end
            end
          end
          ST_REV: begin
            if (beat) begin
              if (dance_pos_q == '0) begin
                state_q     <= ST_FWD;
                dance_pos_q <= dance_pos_q + 1'b1;
              end else begin
                dance_pos_q <= dance_pos_q - 1'b1;
              end
            end
          end
          default: begin
            state_q     <= ST_NORMAL;
            dance_pos_q <= '0;
          end
        endcase
      end
    end
  end

  assign led       = led_q;
  assign dance_pos = dance_pos_q;

endmodule
